// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory req/gnt/rvalid channel plus the decode-side
// queue head and branch redirect. master = fetch unit, slave = memory/decode side.
interface if_fetch_unit_if;
  // imem: a request transfers on a cycle with imem_req & imem_gnt; imem_addr is held
  // stable while imem_req=1 and imem_gnt=0. Its data returns on a later imem_rvalid.
  // decode: the head entry transfers on a cycle with instr_valid & id_ready.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_imm;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc_out;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid, pc_out,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_imm
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, pc_out,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_imm
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, one outstanding imem read, 2-entry queue to decode.
// Define IF_PERF_COUNTERS_EN to add saturating fetch_cnt / flush_cnt outputs.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_unit_if.master bus,
  output logic [1:0]      dbg_state
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     flush_cnt
`endif
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_addr;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        instr_valid;
  logic        take;
  logic        push;
  logic        pop;
  logic [1:0]  count_next;
  logic        room;
  logic [31:0] target;
  logic        unused_imm_hi;

  assign instr_valid   = (count != 2'd0);
  assign unused_imm_hi = ^bus.redirect_imm[31:30];

  // Redirect outranks both the returning word and a decode pop.
  always_comb begin
    take       = bus.redirect_valid & instr_valid;
    push       = (state == S_WAIT) & bus.imem_rvalid & ~take;
    pop        = instr_valid & bus.id_ready & ~take;
    count_next = count + {1'b0, push} - {1'b0, pop};
    room       = (count_next < DEPTH);
    target     = q_pc[rd_ptr] + 32'd4 + {bus.redirect_imm[29:0], 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      fetch_addr <= RESET_PC;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      if (push) begin
        q_instr[wr_ptr] <= bus.imem_rdata;
        q_pc[wr_ptr]    <= fetch_addr;
        wr_ptr          <= ~wr_ptr;
      end

      if (take) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        count <= count_next;
        if (pop) rd_ptr <= ~rd_ptr;
      end

      if (take)
        fetch_pc <= target;
      else if (state == S_REQ && bus.imem_gnt)
        fetch_pc <= fetch_pc + 32'd4;

      if (state == S_REQ && bus.imem_gnt)
        fetch_addr <= fetch_pc;

      case (state)
        S_IDLE: if (!take && room) state <= S_REQ;
        S_REQ: begin
          if (bus.imem_gnt)  state <= take ? S_DROP : S_WAIT;
          else if (take)     state <= S_IDLE;
        end
        S_WAIT: begin
          if (bus.imem_rvalid) state <= (!take && room) ? S_REQ : S_IDLE;
          else if (take)       state <= S_DROP;
        end
        // Response of a wrong-path request still owed by memory; swallow it.
        S_DROP: if (bus.imem_rvalid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IF_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push && fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
      if (take && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

  assign bus.imem_req    = (state == S_REQ);
  assign bus.imem_addr   = fetch_pc;
  assign bus.instruction = q_instr[rd_ptr];
  assign bus.pc_out      = q_pc[rd_ptr];
  assign bus.instr_valid = instr_valid;
  assign dbg_state       = state;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: reactive imem model, directed redirect/reset scenarios,
// scoreboard of expected {pc, instruction} heads checked by a separate monitor.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  dbg_state;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .fetch_cnt (fetch_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q [$];
  logic [31:0] gnt_log [$];
  int          rv_lat    = 1;
  bit          gnt_block = 1'b0;
  logic [31:0] dead_addr = 32'hFFFF_FFFF;
  int          rv_cnt    = 0;
  logic [31:0] rv_addr   = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == dead_addr) return 32'hDEAD_BEEF;
    case (a)
      32'h0:   return 32'h8C01_0004;
      32'h4:   return 32'h0022_1820;
      32'h8:   return 32'h0000_0000;
      default: return {16'hA5A5 ^ a[15:0], a[15:0]};
    endcase
  endfunction

  // Memory: one outstanding read, gnt in the cycle req is seen, rvalid rv_lat cycles later.
  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(rv_addr);
        end
      end else if (bus.imem_req && !gnt_block && !reset) begin
        bus.imem_gnt = 1'b1;
        rv_addr      = bus.imem_addr;
        rv_cnt       = rv_lat;
        gnt_log.push_back(bus.imem_addr);
      end
    end
  end

  // Monitor: every head that leaves the queue (popped or redirected) is scored.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset && bus.instr_valid && (bus.id_ready || bus.redirect_valid)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected pc=%h instr=%h required=none", bus.pc_out, bus.instruction);
        end else begin
          e = exp_q.pop_front();
          if ({bus.pc_out, bus.instruction} !== e) begin
            failures++;
            $display("FAIL sb_head pc=%h instr=%h required pc=%h instr=%h",
                     bus.pc_out, bus.instruction, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_gnt(input string name, input int idx, input logic [31:0] exp);
    checks++;
    if (idx >= gnt_log.size()) begin
      failures++;
      $display("FAIL %s grant#%0d missing required=%h", name, idx, exp);
    end else if (gnt_log[idx] !== exp) begin
      failures++;
      $display("FAIL %s grant#%0d actual=%h required=%h", name, idx, gnt_log[idx], exp);
    end
  endtask

  task automatic expect_head(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_imm   = 32'h0;
    gnt_block          = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    exp_q.delete();
    gnt_log.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    bus.id_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.id_ready = 1'b0;
    check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_head(input string name, input logic [31:0] pc, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(bus.instr_valid && bus.pc_out == pc) && n < budget);
    check(name, bus.instr_valid ? bus.pc_out : 32'hFFFF_FFFF, pc);
  endtask

  initial begin
    int n;
    reset = 1'b1;

    // 1: basic stream, first request timing, address sequence, reset values.
    rv_lat = 1; dead_addr = 32'hFFFF_FFFF;
    do_reset();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_instr", bus.instruction, 32'h0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_pc", bus.pc_out, 32'h0);
    check("rst_state", 32'(dbg_state), 32'd0);
    expect_head(32'h0, 32'h8C01_0004);
    expect_head(32'h4, 32'h0022_1820);
    expect_head(32'h8, 32'h0000_0000);
    bus.id_ready = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("t1_req_idle", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    check("t1_first_req", 32'(bus.imem_req), 32'd1);
    check("t1_first_addr", bus.imem_addr, 32'h0);
    drain("t1", 40);
    check_gnt("t1_addr", 0, 32'h0);
    check_gnt("t1_addr", 1, 32'h4);
    check_gnt("t1_addr", 2, 32'h8);

    // 2: decode stalled, queue fills to 2 and fetch stops, then drains in order.
    do_reset();
    expect_head(32'h0, 32'h8C01_0004);
    expect_head(32'h4, 32'h0022_1820);
    expect_head(32'h8, 32'h0000_0000);
    expect_head(32'hC, 32'hA5A9_000C);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("t2_full_valid", 32'(bus.instr_valid), 32'd1);
    check("t2_full_pc", bus.pc_out, 32'h0);
    check("t2_full_req", 32'(bus.imem_req), 32'd0);
    check("t2_full_grants", 32'(gnt_log.size()), 32'd2);
    check("t2_full_state", 32'(dbg_state), 32'd0);
`ifdef IF_PERF_COUNTERS_EN
    check("t2_fetch_cnt", fetch_cnt, 32'd2);
    check("t2_flush_cnt", flush_cnt, 32'd0);
`endif
    drain("t2", 40);
    check_gnt("t2_resume", 2, 32'h8);
    check_gnt("t2_resume", 3, 32'hC);

    // 3: backward branch from head 0x10 (imm -2) -> target 0x0C, 0x14 dropped.
    do_reset();
    expect_head(32'h0,  32'h8C01_0004);
    expect_head(32'h4,  32'h0022_1820);
    expect_head(32'h8,  32'h0000_0000);
    expect_head(32'hC,  32'hA5A9_000C);
    expect_head(32'h10, 32'hA5B5_0010);
    expect_head(32'hC,  32'hA5A9_000C);
    expect_head(32'h10, 32'hA5B5_0010);
    expect_head(32'h14, 32'hA5B1_0014);
    bus.id_ready = 1'b1;
    reset = 1'b0;
    wait_head("t3_head10", 32'h10, 60);
    bus.redirect_valid = 1'b1;
    bus.redirect_imm   = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.redirect_imm   = 32'h0;
    check("t3_flushed", 32'(bus.instr_valid), 32'd0);
    n = gnt_log.size();
    drain("t3", 60);
    check_gnt("t3_target", n, 32'hC);

    // 4: redirect while in WAIT; late 0xDEADBEEF response is discarded.
    rv_lat = 3; dead_addr = 32'h8;
    do_reset();
    expect_head(32'h0,  32'h8C01_0004);
    expect_head(32'h4,  32'h0022_1820);
    expect_head(32'h1C, 32'hA5B9_001C);
    expect_head(32'h20, 32'hA585_0020);
    bus.id_ready = 1'b1;
    reset = 1'b0;
    wait_head("t4_head4", 32'h4, 60);
    bus.id_ready = 1'b0;
    @(posedge clk);
    #1;
    check("t4_in_wait", 32'(dbg_state), 32'd2);
    bus.redirect_valid = 1'b1;
    bus.redirect_imm   = 32'd5;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.redirect_imm   = 32'h0;
    check("t4_flushed", 32'(bus.instr_valid), 32'd0);
    check("t4_drop_state", 32'(dbg_state), 32'd3);
    n = gnt_log.size();
    drain("t4", 80);
    check_gnt("t4_target", n, 32'h1C);

    // 5: redirect while request is waiting for grant -> withdraw, then re-issue target.
    rv_lat = 1; dead_addr = 32'hFFFF_FFFF;
    do_reset();
    expect_head(32'h0,  32'h8C01_0004);
    expect_head(32'hC,  32'hA5A9_000C);
    expect_head(32'h10, 32'hA5B5_0010);
    bus.id_ready = 1'b1;
    reset = 1'b0;
    wait_head("t5_head0", 32'h0, 20);
    gnt_block          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_imm   = 32'd2;
    check("t5_req_high", 32'(bus.imem_req), 32'd1);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.redirect_imm   = 32'h0;
    check("t5_req_dropped", 32'(bus.imem_req), 32'd0);
    check("t5_idle", 32'(dbg_state), 32'd0);
    check("t5_flushed", 32'(bus.instr_valid), 32'd0);
    gnt_block = 1'b0;
    @(posedge clk);
    #1;
    check("t5_req_again", 32'(bus.imem_req), 32'd1);
    check("t5_req_addr", bus.imem_addr, 32'hC);
    drain("t5", 40);

    // 6: async reset mid-WAIT with a late response arriving after release.
    rv_lat = 3;
    do_reset();
    reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(bus.instr_valid && dbg_state == 2'd2) && n < 60);
    check("t6_wait_reached", 32'(dbg_state), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_req", 32'(bus.imem_req), 32'd0);
    check("t6_async_addr", bus.imem_addr, 32'h0);
    check("t6_async_valid", 32'(bus.instr_valid), 32'd0);
    check("t6_async_instr", bus.instruction, 32'h0);
    check("t6_async_pc", bus.pc_out, 32'h0);
    check("t6_async_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    n = gnt_log.size();
    expect_head(32'h0, 32'h8C01_0004);
    expect_head(32'h4, 32'h0022_1820);
    expect_head(32'h8, 32'h0000_0000);
    reset = 1'b0;
    drain("t6", 80);
    check_gnt("t6_restart", n, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage.
- Owns the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a 2-entry queue and presents them, with their PC, to the decode stage.
- Consumes the decode stage's branch outputs (taken flag plus sign-extended immediate) as a redirect that flushes wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- BUF_DEPTH, 2, instruction queue entries (legal: 2 only; fixed pointer widths).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  byte address of request, word aligned.
- imem_gnt  in  1  memory accepts request this cycle when imem_req=1.
- imem_rvalid  in  1  read data valid, at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- id_ready  in  1  decode consumes head entry this cycle.
- redirect_valid  in  1  branch taken, from decode beq_taken.
- redirect_imm  in  32  sign-extended word offset, from decode beq_imm.
- instruction  out  32  head instruction word to decode.
- instr_valid  out  1  head entry valid.
- pc_out  out  32  PC of head entry.

Behaviour:
- Reset (async, immediate):
  - fetch_pc=RESET_PC; queue empty; state IDLE.
  - imem_req=0, imem_addr=RESET_PC, instruction=0, instr_valid=0, pc_out=0.
- States:
  - IDLE: no request pending.
  - REQ: imem_req=1, awaiting gnt.
  - WAIT: granted, awaiting rvalid.
  - DROP: granted, response will be discarded.
- Only one request outstanding at a time.
- Issue rule: IDLE -> REQ when (queue count + pending) < BUF_DEPTH and no redirect this cycle. The first imem_req is asserted the first cycle after reset deasserts.
- REQ:
  - imem_addr=fetch_pc, held stable while req=1 and gnt=0.
  - On gnt: fetch_pc += 4 (mod 2^32, wraps) and go to WAIT.
- WAIT:
  - On rvalid: push {fetch_addr, imem_rdata}; go to REQ if the issue rule holds, else IDLE.
  - rvalid and gnt may not overlap for the same transaction.
- Queue: the head drives instruction/pc_out/instr_valid. A pushed word is visible 1 cycle after rvalid (registered). Pop when instr_valid & id_ready. Push and pop in the same cycle are allowed. Overflow is impossible by the issue rule.
- Redirect: honoured only when instr_valid=1; ignored otherwise.
  - Target = pc_out + 4 + (redirect_imm << 2), 32-bit wrap.
  - Next cycle: queue flushed (instr_valid=0) and fetch_pc=target.
  - From REQ with gnt=0: the request is withdrawn; go to IDLE, then re-issue the target the following cycle.
  - From REQ with gnt=1, or from WAIT without rvalid: go to DROP.
  - In WAIT with rvalid in the same cycle: the returned word is discarded; go to IDLE.
  - In DROP: the next rvalid is discarded, then go to IDLE.
- Redirect has priority over id_ready; the head is discarded, not popped.
- An rvalid seen in IDLE or REQ (e.g. stale after reset) is ignored.
- imem_rdata content is not interpreted; 32'h0 is queued as a normal word.

Optional Feature:
- Macro IF_PERF_COUNTERS_EN.
- When defined, adds outputs fetch_cnt[31:0] and flush_cnt[31:0].
  - fetch_cnt: words pushed.
  - flush_cnt: honoured redirects.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, RESET_PC=0, memory gnt same cycle and rvalid next cycle with words 0x8C010004, 0x00221820, id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instruction 0x8C010004 with pc_out 0x0, then 0x00221820 with pc_out 0x4.
- id_ready=0 from reset -> queue fills with 2 entries and imem_req stays 0. Raise id_ready -> heads drain in order (pc 0x0, 0x4), then fetching resumes at 0x8.
- Head pc_out 0x10 with redirect_valid=1, redirect_imm=32'hFFFF_FFFE -> next cycle instr_valid=0, then imem_addr=0x0C; pending words from 0x14 never appear.
- Redirect while in WAIT (grant given, rvalid 3 cycles later with 0xDEADBEEF) -> 0xDEADBEEF discarded; the next queued word comes from the target address.
- Redirect while imem_req=1 and gnt=0 -> imem_req drops for 1 cycle, then reasserts with imem_addr=target.
- Assert reset mid-WAIT -> outputs go to reset values without waiting for clk; a late rvalid after reset is ignored; fetch restarts at RESET_PC.
